reset_seq_checker: RTL and testbench
====================================

// Module: reset_seq_checker
// PURPOSE
//  Receive-side counterpart of the TB reset generator: watches a reset line (MON_IN) driven by a
//  generator/DUT, measures each assertion pulse and the released gap after it, and flags protocol
//  violations. Sits in top_env next to the VIP reset generator; outputs feed scoreboard/assertions.
// PARAMETERS
//  ACTIVE_HIGH     1   polarity of MON_IN (1: high = asserted)
//  SYNC_STAGES     2   flops on MON_IN before use (>=1)
//  MIN_ASSERT_CYC  2   shortest legal assertion, cycles
//  MAX_ASSERT_CYC  64  longest legal assertion, cycles
//  MIN_GAP_CYC     16  released cycles required before SEQ_READY / before next legal assertion
//  CNT_W           16  width of cycle counters (all limits < 2**CNT_W-1)
// PORTS
//  CLK_IN     in   1      clock; all logic on rising edge
//  RESET      in   1      asynchronous, active-high reset of this checker
//  MON_IN     in   1      monitored reset line (async to nothing; same clock domain or slower)
//  ERR_CLR    in   1      clears sticky error flags
//  PULSE_DONE out  1      1-cycle strobe: assertion pulse just ended
//  PULSE_LEN  out  CNT_W  measured assertion length; updated with PULSE_DONE, held otherwise
//  PULSE_CNT  out  8      number of completed pulses, saturates at 255
//  SEQ_READY  out  1      released >= MIN_GAP_CYC after a legal pulse
//  ERR_SHORT  out  1      sticky: pulse length < MIN_ASSERT_CYC
//  ERR_LONG   out  1      sticky: assertion exceeded MAX_ASSERT_CYC
//  ERR_GAP    out  1      sticky: re-assertion before MIN_GAP_CYC released cycles
// BEHAVIOUR
//  - RESET=1: all outputs 0, counters 0, state WAIT_REL; immediate (async), release sync to CLK_IN.
//  - mon_s = MON_IN after SYNC_STAGES flops, normalised to 1 = asserted. act = mon_s & ~mon_d.
//  - States: WAIT_REL -> IDLE when mon_s=0 (level asserted at reset exit is ignored, not measured).
//    IDLE: on mon_s=1 -> ACTIVE, cnt=1. ACTIVE: cnt++ each cycle mon_s=1 (saturating at all-ones).
//    ACTIVE, mon_s=0 -> GAP: PULSE_LEN<=cnt, PULSE_DONE=1 for one cycle, PULSE_CNT++, gap=1;
//      ERR_SHORT set if cnt<MIN_ASSERT_CYC.
//    GAP: gap++ while mon_s=0; when gap reaches MIN_GAP_CYC and pulse was legal -> SEQ_READY=1,
//      stay GAP (gap saturates). mon_s=1 in GAP -> ACTIVE, cnt=1, SEQ_READY<=0;
//      ERR_GAP set if gap<MIN_GAP_CYC.
//  - ERR_LONG set in the cycle cnt becomes MAX_ASSERT_CYC+1 (not deferred to pulse end);
//    measurement continues, PULSE_LEN reports full length at end.
//  - Legal pulse = no ERR_SHORT/ERR_LONG raised for that pulse; illegal pulse never gives SEQ_READY.
//  - Latency: PULSE_DONE and PULSE_LEN valid SYNC_STAGES+1 cycles after MON_IN deasserts;
//    SEQ_READY rises SYNC_STAGES+MIN_GAP_CYC cycles after MON_IN deasserts.
//  - ERR_CLR clears all three error flags next cycle; an error set in the same cycle wins.
//  - PULSE_CNT saturates at 255; counters never wrap.
//  - RESET mid-pulse: measurement discarded, no PULSE_DONE, back to WAIT_REL.
// TESTING (SYNC_STAGES=2, defaults otherwise)
//  1 MON_IN 1 for 2 cyc then 0 for 20 -> PULSE_DONE once, PULSE_LEN=2, PULSE_CNT=1,
//    SEQ_READY 1 at cycle 18 after release, no errors.
//  2 MON_IN 1 for 1 cyc -> PULSE_LEN=1, ERR_SHORT=1, SEQ_READY stays 0; ERR_CLR -> ERR_SHORT=0.
//  3 MON_IN 1 for 70 cyc -> ERR_LONG rises on 65th asserted cycle, PULSE_LEN=70, SEQ_READY=0.
//  4 Legal 4-cyc pulse, 5 cyc release, 4-cyc pulse -> ERR_GAP=1, PULSE_CNT=2, SEQ_READY=0
//    until 16 released cycles after 2nd pulse... still 0 (ERR_GAP sticky, pulse 2 legal -> 1).
//  5 MON_IN=1 across RESET release for 10 cyc -> no PULSE_DONE, PULSE_CNT=0; next pulse measured.
//  6 RESET asserted mid-ACTIVE (cnt=5) -> outputs 0 at once, no PULSE_DONE after release.

Source files
------------

// File: rtl/reset_seq_checker.sv
// Receive-side reset line monitor: measures each assertion pulse and the released gap after it,
// strobes completed pulses and raises sticky flags for short, long and too-closely-spaced pulses.
module reset_seq_checker #(
  parameter int ACTIVE_HIGH    = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_ASSERT_CYC = 2,
  parameter int MAX_ASSERT_CYC = 64,
  parameter int MIN_GAP_CYC    = 16,
  parameter int CNT_W          = 16
) (
  input  logic             CLK_IN,
  input  logic             RESET,
  input  logic             MON_IN,
  input  logic             ERR_CLR,
  output logic             PULSE_DONE,
  output logic [CNT_W-1:0] PULSE_LEN,
  output logic [7:0]       PULSE_CNT,
  output logic             SEQ_READY,
  output logic             ERR_SHORT,
  output logic             ERR_LONG,
  output logic             ERR_GAP,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    S_WAIT_REL = 2'd0,
    S_IDLE     = 2'd1,
    S_ACTIVE   = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MIN_A   = CNT_W'(MIN_ASSERT_CYC);
  localparam logic [CNT_W-1:0] MAX_A   = CNT_W'(MAX_ASSERT_CYC);
  localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     gap_q, gap_d;
  logic [CNT_W-1:0]     len_q, len_d;
  logic [7:0]           pcnt_q, pcnt_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic                 bad_q, bad_d;
  logic                 err_short_q, err_long_q, err_gap_q;
  logic                 set_short, set_long, set_gap;
  logic                 mon_raw, mon_s, is_short;

  assign mon_raw = (ACTIVE_HIGH != 0) ? MON_IN : ~MON_IN;
  assign mon_s   = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = mon_raw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronisers come out of reset "asserted" so a line still held at reset exit is never measured.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign is_short = (cnt_q < MIN_A);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    len_d     = len_q;
    pcnt_d    = pcnt_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
    bad_d     = bad_q;
    set_short = 1'b0;
    set_long  = 1'b0;
    set_gap   = 1'b0;
    case (state_q)
      S_WAIT_REL: begin
        if (!mon_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (mon_s) begin
          state_d = S_ACTIVE;
          cnt_d   = CNT_ONE;
          bad_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (mon_s) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == MAX_A) begin
            set_long = 1'b1;
            bad_d    = 1'b1;
          end
        end else begin
          state_d = S_GAP;
          len_d   = cnt_q;
          done_d  = 1'b1;
          gap_d   = CNT_ONE;
          if (pcnt_q != 8'hFF) pcnt_d = pcnt_q + 8'd1;
          if (is_short) begin
            set_short = 1'b1;
            bad_d     = 1'b1;
          end
          // Degenerate gap requirement of one cycle is already met on the exit edge.
          if (!is_short && !bad_q && (MIN_G <= CNT_ONE)) ready_d = 1'b1;
        end
      end
      S_GAP: begin
        if (mon_s) begin
          state_d = S_ACTIVE;
          cnt_d   = CNT_ONE;
          bad_d   = 1'b0;
          ready_d = 1'b0;
          if (gap_q < MIN_G) set_gap = 1'b1;
        end else if (gap_q < MIN_G) begin
          gap_d = gap_q + CNT_ONE;
          if ((gap_d == MIN_G) && !bad_q) ready_d = 1'b1;
        end
      end
      default: state_d = S_WAIT_REL;
    endcase
  end

  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_WAIT_REL;
      cnt_q       <= '0;
      gap_q       <= '0;
      len_q       <= '0;
      pcnt_q      <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      bad_q       <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_gap_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      len_q       <= len_d;
      pcnt_q      <= pcnt_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
      bad_q       <= bad_d;
      // A flag raised in the same cycle as ERR_CLR survives the clear.
      err_short_q <= set_short | (err_short_q & ~ERR_CLR);
      err_long_q  <= set_long  | (err_long_q  & ~ERR_CLR);
      err_gap_q   <= set_gap   | (err_gap_q   & ~ERR_CLR);
    end
  end

  assign PULSE_DONE = done_q;
  assign PULSE_LEN  = len_q;
  assign PULSE_CNT  = pcnt_q;
  assign SEQ_READY  = ready_q;
  assign ERR_SHORT  = err_short_q;
  assign ERR_LONG   = err_long_q;
  assign ERR_GAP    = err_gap_q;
  assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_reset_seq_checker.sv
// Directed bench for reset_seq_checker: pulse shapes with hand-computed strobe timing,
// lengths, counts and flag behaviour, all measured in ticks relative to MON_IN changes.
module tb_reset_seq_checker;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             mon_in;
  logic             err_clr;
  logic             pulse_done;
  logic [CNT_W-1:0] pulse_len;
  logic [7:0]       pulse_cnt;
  logic             seq_ready;
  logic             err_short;
  logic             err_long;
  logic             err_gap;
  logic [1:0]       dbg_state;

  int total_cnt = 0;
  int bad_cnt   = 0;

  reset_seq_checker #(
    .ACTIVE_HIGH(1), .SYNC_STAGES(2), .MIN_ASSERT_CYC(2),
    .MAX_ASSERT_CYC(64), .MIN_GAP_CYC(16), .CNT_W(CNT_W)
  ) dut (
    .CLK_IN(clk), .RESET(rst), .MON_IN(mon_in), .ERR_CLR(err_clr),
    .PULSE_DONE(pulse_done), .PULSE_LEN(pulse_len), .PULSE_CNT(pulse_cnt),
    .SEQ_READY(seq_ready), .ERR_SHORT(err_short), .ERR_LONG(err_long),
    .ERR_GAP(err_gap), .DBG_STATE(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: every drive and sample happens 1ns after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    if (obs != exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n);
    mon_in = 1'b1;
    repeat (n) tick();
    mon_in = 1'b0;
  endtask

  // Release for n ticks; report first PULSE_DONE tick, strobe count and SEQ_READY rise tick.
  task automatic watch(input int n, output int done_at, output int done_n, output int ready_at);
    logic prev;
    done_at  = -1;
    done_n   = 0;
    ready_at = -1;
    prev     = seq_ready;
    mon_in   = 1'b0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (pulse_done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (seq_ready && !prev && ready_at < 0) ready_at = i;
      prev = seq_ready;
    end
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  int done_at, done_n, ready_at, long_at;

  initial begin
    rst = 1'b1; mon_in = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_done", pulse_done, 0);
    chk("rst_len", pulse_len, 0);
    chk("rst_cnt", pulse_cnt, 0);
    chk("rst_ready", seq_ready, 0);
    chk("rst_errs", {err_short, err_long, err_gap}, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("init_idle", dbg_state, 1);

    // 1: legal 2-cycle pulse
    pulse(2);
    watch(20, done_at, done_n, ready_at);
    chk("t1_done_at", done_at, 3);
    chk("t1_done_n", done_n, 1);
    chk("t1_len", pulse_len, 2);
    chk("t1_cnt", pulse_cnt, 1);
    chk("t1_ready_at", ready_at, 18);
    chk("t1_errs", {err_short, err_long, err_gap}, 0);

    // 2: 1-cycle pulse is short
    pulse(1);
    watch(20, done_at, done_n, ready_at);
    chk("t2_done_at", done_at, 3);
    chk("t2_len", pulse_len, 1);
    chk("t2_short", err_short, 1);
    chk("t2_ready", seq_ready, 0);
    chk("t2_ready_at", ready_at, -1);
    chk("t2_gap", err_gap, 0);
    clear_errors();
    chk("t2_clr", err_short, 0);

    // 3: 70-cycle pulse is long
    long_at = -1;
    mon_in = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (err_long && long_at < 0) long_at = i;
    end
    chk("t3_long_at", long_at, 67);
    watch(20, done_at, done_n, ready_at);
    chk("t3_done_at", done_at, 3);
    chk("t3_len", pulse_len, 70);
    chk("t3_cnt", pulse_cnt, 3);
    chk("t3_ready", seq_ready, 0);
    chk("t3_short", err_short, 0);
    clear_errors();
    chk("t3_clr", err_long, 0);

    // 4: re-assertion after only 5 released cycles
    pulse(4);
    watch(5, done_at, done_n, ready_at);
    chk("t4_done1_at", done_at, 3);
    pulse(4);
    watch(20, done_at, done_n, ready_at);
    chk("t4_gap", err_gap, 1);
    chk("t4_cnt", pulse_cnt, 5);
    chk("t4_len", pulse_len, 4);
    chk("t4_ready_at", ready_at, 18);
    chk("t4_short_long", {err_short, err_long}, 0);

    // 5: line held asserted across reset release is ignored
    rst = 1'b1; mon_in = 1'b1;
    tick();
    chk("t5_rst_cnt", pulse_cnt, 0);
    chk("t5_rst_gap", err_gap, 0);
    rst = 1'b0;
    repeat (10) tick();
    watch(20, done_at, done_n, ready_at);
    chk("t5_no_done", done_n, 0);
    chk("t5_cnt0", pulse_cnt, 0);
    pulse(3);
    watch(20, done_at, done_n, ready_at);
    chk("t5_done_at", done_at, 3);
    chk("t5_len", pulse_len, 3);
    chk("t5_cnt1", pulse_cnt, 1);
    chk("t5_ready_at", ready_at, 18);

    // 6: reset in the middle of a pulse (cnt=5)
    mon_in = 1'b1;
    repeat (7) tick();
    chk("t6_active", dbg_state, 2);
    rst = 1'b1;
    #1;
    chk("t6_async_cnt", pulse_cnt, 0);
    chk("t6_async_len", pulse_len, 0);
    chk("t6_async_state", dbg_state, 0);
    mon_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    watch(20, done_at, done_n, ready_at);
    chk("t6_no_done", done_n, 0);
    chk("t6_cnt", pulse_cnt, 0);

    // 7: pulse counter saturates
    for (int i = 0; i < 260; i++) begin
      pulse(2);
      tick(); tick();
    end
    watch(10, done_at, done_n, ready_at);
    chk("t7_sat", pulse_cnt, 255);
    chk("t7_gap", err_gap, 1);
    chk("t7_short", err_short, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
